nzcv_flag_unit: RTL and testbench
=================================

// Module: nzcv_flag_unit
// PURPOSE
// Producer side of the condition-flag interface: computes N/Z/C/V from flag-setting ALU ops (ADDS/SUBS/ANDS),
// holds the architectural NZCV register feeding the branch decoder, and forwards in-flight flags.
// Sits between the execute-stage ALU and the branch/set-condition logic. Two-step path: capture, then commit.
// PARAMETERS
// DW        64   ALU operand/result width
// CNT_W     16   width of commit performance counter
// PORTS
// clk            in   1      rising-edge clock
// rst_n          in   1      asynchronous active-low reset
// alu_valid      in   1      ALU op valid this cycle
// alu_setflags   in   1      op updates flags (S-suffix); ignored unless alu_valid
// alu_op         in   2      00 ADD, 01 SUB (a+~b+1), 10 AND, 11 OTHER (N,Z only)
// alu_a, alu_b   in   DW     ALU operands as presented to the adder (b not yet inverted)
// alu_result     in   DW     ALU result
// alu_cout       in   1      adder carry-out (SUB: 1 = no borrow)
// flush          in   1      kill in-flight and same-cycle flag op
// nzcv_wr_en     in   1      direct write (MSR NZCV)
// nzcv_wr_data   in   4      {N,Z,C,V} for direct write
// N, Z, C, V     out  1 ea   architectural flags (registered)
// nzcv_fwd       out  4      {N,Z,C,V} as they will be after the pending commit; = arch when nothing pending
// flags_pending  out  1      flag op held in capture stage (commits at end of this cycle)
// commit_cnt     out  CNT_W  number of flag commits since reset
// BEHAVIOUR
// - Reset (async, rst_n=0): N=Z=C=V=0, capture stage empty, flags_pending=0, commit_cnt=0, nzcv_fwd=0000.
// - Capture (edge t): alu_valid & alu_setflags & ~flush -> stage <= {op, a[DW-1], b[DW-1], result[DW-1],
//   result==0, alu_cout}; stage_valid <= 1. Otherwise stage_valid <= 0. Only MSBs/zero bit stored.
// - Commit: while stage_valid (cycle t+1) and ~flush, NZCV register loads computed flags at edge t+1;
//   new flags visible on N/Z/C/V at t+2. Latency valid->architectural = 2 edges; ->nzcv_fwd = 1 edge.
// - Flag arithmetic (from stage): N=res_msb; Z=res_zero;
//   ADD: C=cout, V=(a_msb==b_msb)&(res_msb!=a_msb);  SUB: C=cout, V=(a_msb!=b_msb)&(res_msb!=a_msb);
//   AND: C=0, V=0;  OTHER: C,V keep current architectural values.
// - nzcv_fwd combinational: stage_valid&~flush ? computed flags : {N,Z,C,V}. Branch logic reads this.
// - Back-to-back flag ops: each occupies stage for one cycle; in-order commits; no stall, no bubble.
// - flush: clears stage_valid at next edge, suppresses that cycle's commit and capture, forces
//   flags_pending=0 and nzcv_fwd=arch combinationally. Architectural NZCV unchanged by flush.
// - Direct write: nzcv_wr_en loads nzcv_wr_data at edge. Same cycle as commit: MSR is younger, wins.
//   MSR does not count as commit. flush does not block nzcv_wr_en.
// - alu_valid without alu_setflags, or alu_setflags without alu_valid: no capture, flags held.
// - commit_cnt increments on each non-flushed commit; wraps 2^CNT_W-1 -> 0.
// - Reset asserted mid-operation: pending commit discarded, all state to reset values immediately.
// STRUCTURE
// - Shared package cpu_pkg: FLAG_OP_ADD/SUB/AND/OTHER encodings, NZCV bit indices (N=3,Z=2,C=1,V=0).
// - Sub-module nzcv_compute (combinational): stage fields + current C,V -> 4-bit flags; reused by
//   commit and nzcv_fwd paths. Top holds stage regs, NZCV reg, counter, muxing.
// TESTING
// - SUBS a=5,b=5,res=0,cout=1 -> nzcv_fwd=0110 at t+1, NZCV=0110 at t+2, commit_cnt=1.
// - ADDS a=0x7FFF_FFFF_FFFF_FFFF,b=1,res=0x8000_0000_0000_0000,cout=0 -> NZCV=1001; then
//   OTHER op res=0 -> NZCV=0101 (C,V held).
// - Back-to-back SUBS 3-5 (res=-2,cout=0 -> 1000) then ANDS res=0 -> NZCV 1000 then 0100 on consecutive
//   cycles; nzcv_fwd leads each by one cycle.
// - SUBS captured, flush asserted next cycle -> NZCV unchanged, flags_pending=0, commit_cnt unchanged.
// - Commit and nzcv_wr_en=1,data=1111 same cycle -> NZCV=1111, commit_cnt still increments.
// - Drive commit_cnt to 0xFFFF, one more commit -> 0x0000; assert rst_n=0 mid-pending -> all outputs 0.

Source files
------------

// File: rtl/cpu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cpu_pkg: condition-flag op encodings, NZCV bit positions, capture stage type |
// | Rev 1.0                                                                      |
// +----------------------------------------------------------------------------+
package cpu_pkg;

    localparam logic [1:0] FLAG_OP_ADD   = 2'b00;
    localparam logic [1:0] FLAG_OP_SUB   = 2'b01;
    localparam logic [1:0] FLAG_OP_AND   = 2'b10;
    localparam logic [1:0] FLAG_OP_OTHER = 2'b11;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // Only the sign bits and the zero indication are needed to derive NZCV later.
    typedef struct packed {
        logic [1:0] op;
        logic       a_msb;
        logic       b_msb;
        logic       res_msb;
        logic       res_zero;
        logic       cout;
    } flag_stage_t;

endpackage
`default_nettype wire

// File: rtl/nzcv_compute.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | nzcv_compute: combinational NZCV derivation from a captured flag stage       |
// | Rev 1.0                                                                      |
// +----------------------------------------------------------------------------+
module nzcv_compute
    import cpu_pkg::*;
(
    input  logic        [0:0] c_cur_i,
    input  logic        [0:0] v_cur_i,
    input  flag_stage_t       stage_i,
    output logic        [3:0] flags_o
);

    always_comb begin
        flags_o         = 4'b0000;
        flags_o[FLAG_N] = stage_i.res_msb;
        flags_o[FLAG_Z] = stage_i.res_zero;
        case (stage_i.op)
            FLAG_OP_ADD: begin
                flags_o[FLAG_C] = stage_i.cout;
                flags_o[FLAG_V] = (stage_i.a_msb == stage_i.b_msb) &&
                                  (stage_i.res_msb != stage_i.a_msb);
            end
            FLAG_OP_SUB: begin
                // b is captured un-inverted, so signed overflow needs differing signs.
                flags_o[FLAG_C] = stage_i.cout;
                flags_o[FLAG_V] = (stage_i.a_msb != stage_i.b_msb) &&
                                  (stage_i.res_msb != stage_i.a_msb);
            end
            FLAG_OP_AND: begin
                flags_o[FLAG_C] = 1'b0;
                flags_o[FLAG_V] = 1'b0;
            end
            default: begin
                flags_o[FLAG_C] = c_cur_i[0];
                flags_o[FLAG_V] = v_cur_i[0];
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/nzcv_flag_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | nzcv_flag_unit: capture/commit of ALU condition flags, forwarding, MSR write |
// | Rev 1.0                                                                      |
// +----------------------------------------------------------------------------+
module nzcv_flag_unit
    import cpu_pkg::*;
#(
    parameter int DW    = 64,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             alu_valid,
    input  logic             alu_setflags,
    input  logic [1:0]       alu_op,
    input  logic [DW-1:0]    alu_a,
    input  logic [DW-1:0]    alu_b,
    input  logic [DW-1:0]    alu_result,
    input  logic             alu_cout,
    input  logic             flush,
    input  logic             nzcv_wr_en,
    input  logic [3:0]       nzcv_wr_data,
    output logic             N,
    output logic             Z,
    output logic             C,
    output logic             V,
    output logic [3:0]       nzcv_fwd,
    output logic             flags_pending,
    output logic [CNT_W-1:0] commit_cnt
);

    flag_stage_t      stage_q, stage_d;
    logic             stage_valid_q, stage_valid_d;
    logic [3:0]       nzcv_q, nzcv_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             w_capture;
    logic             w_commit;
    logic [3:0]       w_flags;
    logic             w_unused_bits;

    assign w_unused_bits = ^{alu_a[DW-2:0], alu_b[DW-2:0]};

    assign w_capture = alu_valid & alu_setflags & ~flush;
    assign w_commit  = stage_valid_q & ~flush;

    nzcv_compute u_compute (
        .c_cur_i (nzcv_q[FLAG_C]),
        .v_cur_i (nzcv_q[FLAG_V]),
        .stage_i (stage_q),
        .flags_o (w_flags)
    );

    always_comb begin
        stage_valid_d = w_capture;
        stage_d       = stage_q;
        if (w_capture) begin
            stage_d.op       = alu_op;
            stage_d.a_msb    = alu_a[DW-1];
            stage_d.b_msb    = alu_b[DW-1];
            stage_d.res_msb  = alu_result[DW-1];
            stage_d.res_zero = (alu_result == '0);
            stage_d.cout     = alu_cout;
        end

        // MSR is younger than the committing op, so it takes priority.
        nzcv_d = nzcv_q;
        if (nzcv_wr_en) begin
            nzcv_d = nzcv_wr_data;
        end else if (w_commit) begin
            nzcv_d = w_flags;
        end

        cnt_d = w_commit ? cnt_q + 1'b1 : cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_q       <= '0;
            stage_valid_q <= 1'b0;
            nzcv_q        <= 4'b0000;
            cnt_q         <= '0;
        end else begin
            stage_q       <= stage_d;
            stage_valid_q <= stage_valid_d;
            nzcv_q        <= nzcv_d;
            cnt_q         <= cnt_d;
        end
    end

    assign N             = nzcv_q[FLAG_N];
    assign Z             = nzcv_q[FLAG_Z];
    assign C             = nzcv_q[FLAG_C];
    assign V             = nzcv_q[FLAG_V];
    assign nzcv_fwd      = w_commit ? w_flags : nzcv_q;
    assign flags_pending = w_commit;
    assign commit_cnt    = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_nzcv_flag_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_nzcv_flag_unit: directed self-checking bench for nzcv_flag_unit           |
// | Rev 1.0                                                                      |
// +----------------------------------------------------------------------------+
module tb_nzcv_flag_unit;

    localparam int DW    = 64;
    localparam int CNT_W = 16;

    logic             clk;
    logic             rst_n;
    logic             alu_valid;
    logic             alu_setflags;
    logic [1:0]       alu_op;
    logic [DW-1:0]    alu_a;
    logic [DW-1:0]    alu_b;
    logic [DW-1:0]    alu_result;
    logic             alu_cout;
    logic             flush;
    logic             nzcv_wr_en;
    logic [3:0]       nzcv_wr_data;
    logic             N, Z, C, V;
    logic [3:0]       nzcv_fwd;
    logic             flags_pending;
    logic [CNT_W-1:0] commit_cnt;

    int checks = 0;
    int errors = 0;
    int exp_cnt = 0;

    nzcv_flag_unit #(.DW(DW), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .alu_valid     (alu_valid),
        .alu_setflags  (alu_setflags),
        .alu_op        (alu_op),
        .alu_a         (alu_a),
        .alu_b         (alu_b),
        .alu_result    (alu_result),
        .alu_cout      (alu_cout),
        .flush         (flush),
        .nzcv_wr_en    (nzcv_wr_en),
        .nzcv_wr_data  (nzcv_wr_data),
        .N             (N),
        .Z             (Z),
        .C             (C),
        .V             (V),
        .nzcv_fwd      (nzcv_fwd),
        .flags_pending (flags_pending),
        .commit_cnt    (commit_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic op(input logic v, input logic s, input logic [1:0] o,
                      input logic [DW-1:0] a, input logic [DW-1:0] b,
                      input logic [DW-1:0] r, input logic co);
        alu_valid    = v;
        alu_setflags = s;
        alu_op       = o;
        alu_a        = a;
        alu_b        = b;
        alu_result   = r;
        alu_cout     = co;
    endtask

    task automatic idle();
        op(1'b0, 1'b0, 2'b00, '0, '0, 64'h1, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        nzcv_wr_en = 1'b0;
        nzcv_wr_data = 4'b0000;
        idle();
        #1;
        check("reset_nzcv", {28'd0, N, Z, C, V}, 32'h0);
        check("reset_fwd", {28'd0, nzcv_fwd}, 32'h0);
        check("reset_pending", {31'd0, flags_pending}, 32'h0);
        check("reset_cnt", {16'd0, commit_cnt}, 32'h0);
        tick();
        rst_n = 1'b1;
        tick();

        // SUBS 5-5
        op(1'b1, 1'b1, 2'b01, 64'd5, 64'd5, 64'd0, 1'b1);
        tick();
        idle();
        check("subs_fwd_t1", {28'd0, nzcv_fwd}, 32'h6);
        check("subs_pend_t1", {31'd0, flags_pending}, 32'h1);
        check("subs_arch_t1", {28'd0, N, Z, C, V}, 32'h0);
        tick();
        exp_cnt = 1;
        check("subs_arch_t2", {28'd0, N, Z, C, V}, 32'h6);
        check("subs_cnt", {16'd0, commit_cnt}, exp_cnt);
        check("subs_pend_t2", {31'd0, flags_pending}, 32'h0);

        // ADDS overflow, then OTHER keeps C,V
        op(1'b1, 1'b1, 2'b00, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'h8000_0000_0000_0000, 1'b0);
        tick();
        idle();
        tick();
        exp_cnt++;
        check("adds_ovf", {28'd0, N, Z, C, V}, 32'h9);
        op(1'b1, 1'b1, 2'b11, 64'd3, 64'd3, 64'd0, 1'b1);
        tick();
        idle();
        tick();
        exp_cnt++;
        check("other_hold_cv", {28'd0, N, Z, C, V}, 32'h5);

        // setflags without valid, and valid without setflags: no capture
        op(1'b0, 1'b1, 2'b10, 64'd0, 64'd0, 64'd0, 1'b0);
        tick();
        check("nosetv_pend", {31'd0, flags_pending}, 32'h0);
        op(1'b1, 1'b0, 2'b10, 64'd0, 64'd0, 64'd0, 1'b0);
        tick();
        idle();
        tick();
        check("nosets_arch", {28'd0, N, Z, C, V}, 32'h5);
        check("nosets_cnt", {16'd0, commit_cnt}, exp_cnt);

        // Back-to-back SUBS 3-5 then ANDS res=0
        op(1'b1, 1'b1, 2'b01, 64'd3, 64'd5, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
        tick();
        check("b2b_fwd1", {28'd0, nzcv_fwd}, 32'h8);
        op(1'b1, 1'b1, 2'b10, 64'hF0, 64'h0F, 64'd0, 1'b0);
        tick();
        idle();
        exp_cnt++;
        check("b2b_arch1", {28'd0, N, Z, C, V}, 32'h8);
        check("b2b_fwd2", {28'd0, nzcv_fwd}, 32'h4);
        tick();
        exp_cnt++;
        check("b2b_arch2", {28'd0, N, Z, C, V}, 32'h4);
        check("b2b_cnt", {16'd0, commit_cnt}, exp_cnt);

        // Flush kills a captured SUBS
        op(1'b1, 1'b1, 2'b01, 64'd7, 64'd7, 64'd0, 1'b1);
        tick();
        idle();
        flush = 1'b1;
        #1;
        check("flush_pend", {31'd0, flags_pending}, 32'h0);
        check("flush_fwd", {28'd0, nzcv_fwd}, 32'h4);
        tick();
        flush = 1'b0;
        check("flush_arch", {28'd0, N, Z, C, V}, 32'h4);
        check("flush_cnt", {16'd0, commit_cnt}, exp_cnt);

        // Flush in the capture cycle suppresses the capture
        op(1'b1, 1'b1, 2'b01, 64'd7, 64'd7, 64'd0, 1'b1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        idle();
        check("flush_cap_pend", {31'd0, flags_pending}, 32'h0);

        // Commit and MSR in the same cycle: MSR wins, commit still counts
        op(1'b1, 1'b1, 2'b00, 64'd1, 64'd1, 64'd2, 1'b0);
        tick();
        idle();
        nzcv_wr_en = 1'b1;
        nzcv_wr_data = 4'b1111;
        tick();
        nzcv_wr_en = 1'b0;
        exp_cnt++;
        check("msr_win", {28'd0, N, Z, C, V}, 32'hF);
        check("msr_cnt", {16'd0, commit_cnt}, exp_cnt);

        // MSR under flush still writes
        nzcv_wr_en = 1'b1;
        nzcv_wr_data = 4'b0011;
        flush = 1'b1;
        tick();
        nzcv_wr_en = 1'b0;
        flush = 1'b0;
        check("msr_flush", {28'd0, N, Z, C, V}, 32'h3);

        // Counter wrap: commit back-to-back up to 0xFFFF, then one more
        op(1'b1, 1'b1, 2'b10, 64'd1, 64'd1, 64'd1, 1'b0);
        for (int i = exp_cnt; i < 65535; i++) tick();
        idle();
        tick();
        check("cnt_max", {16'd0, commit_cnt}, 32'hFFFF);
        op(1'b1, 1'b1, 2'b10, 64'd1, 64'd1, 64'd1, 1'b0);
        tick();
        idle();
        tick();
        check("cnt_wrap", {16'd0, commit_cnt}, 32'h0);

        // Async reset while a commit is pending
        op(1'b1, 1'b1, 2'b01, 64'd9, 64'd9, 64'd0, 1'b1);
        tick();
        idle();
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_nzcv", {28'd0, N, Z, C, V}, 32'h0);
        check("rst_mid_fwd", {28'd0, nzcv_fwd}, 32'h0);
        check("rst_mid_pend", {31'd0, flags_pending}, 32'h0);
        tick();
        check("rst_mid_hold", {16'd0, commit_cnt}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
